// File: rtl/pkt_pkg.sv
// Shared packet-path constants and helpers for the ingress header capture and filter core.
package pkt_pkg;

    localparam int DATA_W    = 64;
    localparam int HDR_W     = 512;
    localparam int HDR_BEATS = HDR_W / DATA_W;
    localparam int KEEP_W    = DATA_W / 8;
    localparam int POP_W     = $clog2(KEEP_W + 1);

    typedef enum logic [1:0] {
        CAPTURE = 2'd0,
        SKIP    = 2'd1,
        HOLD    = 2'd2
    } hc_state_e;

    function automatic logic [POP_W-1:0] keep_popcount(input logic [KEEP_W-1:0] keep);
        logic [POP_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            cnt = cnt + {{(POP_W-1){1'b0}}, keep[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/header_capture.sv
// Ingress header capture: latches the first HDR_W bits of a packet, counts its bytes,
// and hands header/length/runt flag downstream over a valid/ready handshake.
module header_capture
    import pkt_pkg::*;
#(
    parameter int DATA_W = pkt_pkg::DATA_W,
    parameter int HDR_W  = pkt_pkg::HDR_W,
    parameter int CNT_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic [DATA_W/8-1:0]   s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tlast,
    output logic                  s_tready,
    output logic [HDR_W-1:0]      hdr_data,
    output logic [15:0]           hdr_len,
    output logic                  hdr_short,
    output logic                  hdr_valid,
    input  logic                  hdr_ready,
    output logic [CNT_W-1:0]      pkt_cnt,
    output logic [CNT_W-1:0]      runt_cnt
);

    localparam int          BEATS     = HDR_W / DATA_W;
    localparam int          KW        = DATA_W / 8;
    localparam int          IDX_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [15:0] HDR_BYTES = 16'(HDR_W / 8);

    hc_state_e              r_state;
    hc_state_e              w_state_next;
    logic [IDX_W-1:0]       r_beat_idx;
    logic [HDR_W-1:0]       r_hdr_data;
    logic [15:0]            r_len;
    logic                   r_short;
    logic [CNT_W-1:0]       r_pkt_cnt;
    logic [CNT_W-1:0]       r_runt_cnt;

    logic [DATA_W-1:0]      w_beat_masked;
    logic                   w_accept;
    logic                   w_handoff;
    logic [16:0]            w_len_sum;
    logic [15:0]            w_len_next;

    // Masked-off bytes land in the header as zero, following tkeep bit-for-bit.
    genvar gi;
    generate
        for (gi = 0; gi < KW; gi++) begin : g_mask
            assign w_beat_masked[gi*8 +: 8] = s_tkeep[gi] ? s_tdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    assign s_tready   = (r_state != HOLD);
    assign w_accept   = s_tvalid && s_tready;
    assign w_handoff  = (r_state == HOLD) && hdr_ready;
    assign w_len_sum  = {1'b0, r_len} + 17'(keep_popcount(s_tkeep));
    assign w_len_next = w_len_sum[16] ? 16'hFFFF : w_len_sum[15:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            CAPTURE: begin
                if (w_accept) begin
                    if (s_tlast) begin
                        w_state_next = HOLD;
                    end else if (r_beat_idx == IDX_W'(BEATS - 1)) begin
                        w_state_next = SKIP;
                    end
                end
            end
            SKIP: begin
                if (w_accept && s_tlast) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (hdr_ready) begin
                    w_state_next = CAPTURE;
                end
            end
            default: w_state_next = CAPTURE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= CAPTURE;
            r_beat_idx <= '0;
            r_hdr_data <= '0;
            r_len      <= '0;
            r_short    <= 1'b0;
            r_pkt_cnt  <= '0;
            r_runt_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_len <= w_len_next;
                if (s_tlast) begin
                    r_short <= (w_len_next < HDR_BYTES);
                end
                if (r_state == CAPTURE) begin
                    r_beat_idx <= r_beat_idx + 1'b1;
                    // Beat 0 starts a fresh header, so stale bytes of a longer predecessor vanish.
                    if (r_beat_idx == '0) begin
                        r_hdr_data <= HDR_W'(w_beat_masked);
                    end else begin
                        r_hdr_data[int'(r_beat_idx)*DATA_W +: DATA_W] <= w_beat_masked;
                    end
                end
            end
            if (w_handoff) begin
                r_beat_idx <= '0;
                r_len      <= '0;
                r_pkt_cnt  <= r_pkt_cnt + 1'b1;
                if (r_short) begin
                    r_runt_cnt <= r_runt_cnt + 1'b1;
                end
            end
        end
    end

    assign hdr_data  = r_hdr_data;
    assign hdr_len   = r_len;
    assign hdr_short = r_short;
    assign hdr_valid = (r_state == HOLD);
    assign pkt_cnt   = r_pkt_cnt;
    assign runt_cnt  = r_runt_cnt;

endmodule
